// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative radix-2 RV32M multiply/divide unit for the Execute stage.
// Optional macro MULDIV_EARLY_OUT_EN: zero multiplies and |a|<|b| divides finish in one cycle.
module muldiv_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            startE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] src_aE,
    input  logic [XLEN-1:0] src_bE,
    input  logic            killE,
    output logic            stall_reqE,
    output logic            doneE,
    output logic [XLEN-1:0] resultE
);
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned ACC_W = 2 * XLEN;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2:0]        op_q, op_d;
    logic              a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic              done_d;
    logic [XLEN-1:0]   result_d;

    // Operand decode: signedness per funct3 and unsigned magnitudes
    logic            sgn_a, sgn_b, a_neg_in, b_neg_in;
    logic [XLEN-1:0] mag_a, mag_b;

    assign sgn_a    = funct3E[2] ? ~funct3E[0] : (funct3E[1] ^ funct3E[0]);
    assign sgn_b    = funct3E[2] ? ~funct3E[0] : (~funct3E[1] & funct3E[0]);
    assign a_neg_in = sgn_a & src_aE[XLEN-1];
    assign b_neg_in = sgn_b & src_bE[XLEN-1];
    assign mag_a    = a_neg_in ? -src_aE : src_aE;
    assign mag_b    = b_neg_in ? -src_bE : src_bE;

    // Single-cycle cases resolved directly from the E-stage operands
    logic            div_zero, div_ovf, early_hit, div_small, fast;
    logic [XLEN-1:0] fast_res;

    assign div_zero = funct3E[2] & (src_bE == '0);
    assign div_ovf  = funct3E[2] & ~funct3E[0] & (src_aE == XMIN) & (src_bE == '1);

`ifdef MULDIV_EARLY_OUT_EN
    logic mul_zero;
    assign mul_zero  = ~funct3E[2] & ((src_aE == '0) | (src_bE == '0));
    assign div_small = funct3E[2] & (src_bE != '0) & (mag_a < mag_b);
    assign early_hit = mul_zero | div_small;
`else
    assign div_small = 1'b0;
    assign early_hit = 1'b0;
`endif

    assign fast = div_zero | div_ovf | early_hit;

    always_comb begin
        fast_res = '0;
        if (div_zero) begin
            fast_res = funct3E[1] ? src_aE : '1;
        end else if (div_ovf) begin
            fast_res = funct3E[1] ? '0 : src_aE;
        end else if (div_small) begin
            fast_res = funct3E[1] ? src_aE : '0;
        end
    end

    // One radix-2 step: shift-add multiply or restoring divide on acc {hi, lo}
    logic [XLEN:0]   mul_sum, rem_sh;
    logic [XLEN-1:0] diff;
    logic            ge;
    logic [ACC_W-1:0] mul_next, div_next, step_acc;

    assign mul_sum  = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign rem_sh   = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-1]};
    assign ge       = rem_sh >= {1'b0, opnd_q};
    assign diff     = rem_sh[XLEN-1:0] - opnd_q;
    assign div_next = {(ge ? diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], ge};
    assign step_acc = op_q[2] ? div_next : mul_next;

    // Sign fixup and result selection from the final step
    logic [ACC_W-1:0] prod;
    logic [XLEN-1:0]  quo, rem, final_res;

    assign prod = (a_neg_q ^ b_neg_q) ? -step_acc : step_acc;
    assign quo  = step_acc[XLEN-1:0];
    assign rem  = step_acc[ACC_W-1:XLEN];

    always_comb begin
        final_res = '0;
        if (!op_q[2]) begin
            final_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[ACC_W-1:XLEN];
        end else if (!op_q[1]) begin
            final_res = (a_neg_q ^ b_neg_q) ? -quo : quo;
        end else begin
            final_res = a_neg_q ? -rem : rem;
        end
    end

    assign stall_reqE = startE & ~killE & (state_q != DONE);

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        done_d   = 1'b0;
        result_d = resultE;

        unique case (state_q)
            IDLE: begin
                if (startE && !killE) begin
                    op_d    = funct3E;
                    a_neg_d = a_neg_in;
                    b_neg_d = b_neg_in;
                    cnt_d   = '0;
                    if (fast) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = fast_res;
                    end else begin
                        state_d = BUSY;
                        acc_d   = {{XLEN{1'b0}}, (funct3E[2] ? mag_a : mag_b)};
                        opnd_d  = funct3E[2] ? mag_b : mag_a;
                    end
                end
            end
            BUSY: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = final_res;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (killE) begin
            state_d  = IDLE;
            cnt_d    = '0;
            done_d   = 1'b0;
            result_d = resultE;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            doneE   <= 1'b0;
            resultE <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            doneE   <= done_d;
            resultE <= result_d;
        end
    end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative RV32M multiply/divide unit in the Execute stage.
- Accepts an M-extension op from E-stage operands and computes it over multiple cycles.
- Raises a stall request into the hazard logic, which freezes F/D/E while the unit is busy.
- Delivers a one-cycle done pulse with the result so the instruction advances to Memory.

Parameters:
XLEN, 32, operand/result width; any even value >= 8.
CNT_W, $clog2(XLEN), iteration counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
startE  input  1  valid M-op in E; held high while stalled
funct3E  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_aE  input  XLEN  rs1 operand (forwarded value)
src_bE  input  XLEN  rs2 operand (forwarded value)
killE  input  1  abort in-flight op (exception/flush); no result produced
stall_reqE  output  1  combinational; ORed into stallF/stallD/stallE by hazard logic
doneE  output  1  registered one-cycle pulse: resultE valid
resultE  output  XLEN  result; holds last value until next done

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, cnt=0, doneE=0, resultE=0, internal accumulators 0. Reset mid-operation discards the op and returns to IDLE.
- States: IDLE, BUSY, DONE.
- IDLE, startE=1 & killE=0 in cycle T:
  - Latch funct3 and operand magnitudes.
  - Latch signs: rs1 signed for MULH/MULHSU/DIV/REM; rs2 signed for MULH/DIV/REM.
  - Go to BUSY (cnt=0), or to DONE directly for a fast path.
- BUSY: one radix-2 step per cycle.
  - MUL*: shift-add of |a|*|b| into a 2*XLEN accumulator.
  - DIV*/REM*: restoring division of |a| by |b|.
  - After the step with cnt=XLEN-1, go to DONE; cnt wraps to 0.
- Sign fixup, applied when latching resultE:
  - Product: negate if the operand signs differ.
  - Quotient: negate if the signs differ.
  - Remainder: takes the sign of the dividend.
- DONE: doneE=1 and resultE valid for exactly this cycle; next state IDLE unconditionally. startE in DONE is ignored, since it is the same instruction about to leave E.
- Result selection:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- stall_reqE = startE & ~killE & (state != DONE).
  - Asserted in cycles T..T+XLEN on the full path; low in the DONE cycle.
- Latency, full path: start at T, BUSY T+1..T+XLEN, doneE at T+XLEN+1 (T+33 for XLEN=32).
- Fast paths (always present), done at T+1:
  - Divide by zero: quotient = all ones; remainder = src_aE.
  - Signed overflow (DIV/REM, a=-2^(XLEN-1), b=-1): quotient = a; remainder = 0.
- killE:
  - In any state: next state IDLE, doneE=0, resultE unchanged.
  - With startE in IDLE: op not accepted.
- Back-to-back: a new op may start in the cycle after DONE (IDLE with startE high).
- All arithmetic on unsigned magnitudes; the 2*XLEN product never overflows.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined, these cases go IDLE -> DONE with doneE at T+1:
  - MUL*: either operand is 0; result 0.
  - DIV*/REM*: |a| < |b| with b != 0; quotient 0, remainder = a.
- Not defined: these cases take the full XLEN+1-cycle path with identical results.

Test Plan:
- MUL 7 * 0xFFFFFFFD at T -> stall_reqE high T..T+32, doneE only at T+33, resultE=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 100/0 -> 0xFFFFFFFF and REM 100/0 -> 100, both doneE at T+1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, doneE at T+1.
- Start DIV, assert killE at T+10 -> IDLE at T+11, no doneE, resultE unchanged; new MUL 3*4 at T+12 -> 12 at T+45.
- Back-to-back: MUL done at T+33, new DIVU 9/3 start at T+34 -> 3 at T+67; with MULDIV_EARLY_OUT_EN, MUL 5*0 -> 0 at T+1 and DIVU 3/9 -> 0 at T+1.
